// File: rtl/inst_fetch_buffer_if.sv
// inst_fetch_buffer_if: memory-side and core-side handshake bundle of the fetch buffer
interface inst_fetch_buffer_if;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [31:0] inst_addr;
  logic        inst_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  modport master (
    output mem_valid, mem_addr, inst_valid, inst_data, inst_addr,
    input  mem_ready, mem_rvalid, mem_rdata, inst_ready, redirect, redirect_pc
  );
  modport slave (
    input  mem_valid, mem_addr, inst_valid, inst_data, inst_addr,
    output mem_ready, mem_rvalid, mem_rdata, inst_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/inst_fetch_buffer.sv
// inst_fetch_buffer: sequential instruction prefetch with credit-limited FIFO and redirect flush
module inst_fetch_buffer #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic            clk,
  input logic            rst,
  inst_fetch_buffer_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [31:0]   fetch_pc, resp_pc;
  logic [CW-1:0] outstanding, drop_cnt, count;
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [31:0]   addr_q [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic [CW:0]   credit_used;
  logic [31:0]   new_pc;
  logic          accept, drop, push, pop;
  // buffered + in-flight-but-kept responses must never exceed FIFO capacity
  assign credit_used   = {1'b0, count} + {1'b0, outstanding} - {1'b0, drop_cnt};
  assign bus.mem_valid = !rst && !bus.redirect && (credit_used < (CW+1)'(DEPTH));
  assign bus.mem_addr  = fetch_pc;
  assign accept        = bus.mem_valid && bus.mem_ready;
  assign drop          = bus.mem_rvalid && (drop_cnt != '0);
  assign push          = bus.mem_rvalid && !drop && !bus.redirect;
  assign pop           = bus.inst_valid && bus.inst_ready && !bus.redirect;
  assign new_pc        = bus.redirect_pc & ~32'h3;
  assign bus.inst_valid = (count != '0);
  assign bus.inst_data  = data_q[rd_ptr];
  assign bus.inst_addr  = addr_q[rd_ptr];
  // request/response bookkeeping; redirect overrides everything else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else if (bus.redirect) begin
      fetch_pc    <= new_pc;
      resp_pc     <= new_pc;
      outstanding <= outstanding - CW'(bus.mem_rvalid);
      drop_cnt    <= outstanding - CW'(bus.mem_rvalid);
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else begin
      fetch_pc    <= accept ? fetch_pc + 32'd4 : fetch_pc;
      resp_pc     <= push ? resp_pc + 32'd4 : resp_pc;
      outstanding <= outstanding + CW'(accept) - CW'(bus.mem_rvalid);
      drop_cnt    <= drop_cnt - CW'(drop);
      count       <= count + CW'(push) - CW'(pop);
      rd_ptr      <= pop ? rd_ptr + AW'(1) : rd_ptr;
      wr_ptr      <= push ? wr_ptr + AW'(1) : wr_ptr;
    end
  end
  // FIFO storage of {addr, data}, cleared on reset so the head reads zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else if (push) begin
      addr_q[wr_ptr] <= resp_pc;
      data_q[wr_ptr] <= bus.mem_rdata;
    end
  end
endmodule

// File: tb/tb_inst_fetch_buffer.sv
// tb_inst_fetch_buffer: scoreboard bench with a variable-latency memory model
module tb_inst_fetch_buffer;
  localparam logic [31:0] K = 32'hA5A5_A5A5;
  logic clk = 1'b0;
  logic rst = 1'b1;
  inst_fetch_buffer_if bus();
  inst_fetch_buffer #(.DEPTH(4), .RESET_PC(32'h0)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int lat = 1;
  int n_acc = 0;
  logic [31:0] exp_pc = 32'h0;
  logic [31:0] ea;
  logic [31:0] exp_q [$];
  logic [31:0] pend_addr [$];
  int pend_due [$];
  logic [31:0] wrap_exp [4];
  // memory model + scoreboard: acts at negedge for the upcoming posedge
  initial begin
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = 32'h0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        exp_q.delete();
        pend_addr.delete();
        pend_due.delete();
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 32'h0;
        exp_pc = 32'h0;
        n_acc  = 0;
      end else begin
        if (bus.inst_valid && bus.inst_ready && !bus.redirect) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL deliver_stale got addr %h, nothing expected", bus.inst_addr);
          end else begin
            ea = exp_q.pop_front();
            if (bus.inst_addr !== ea || bus.inst_data !== (ea ^ K)) begin
              errors++;
              $display("FAIL deliver got addr %h data %h expected addr %h data %h", bus.inst_addr, bus.inst_data, ea, ea ^ K);
            end
          end
        end
        if (bus.redirect) begin
          checks++;
          if (bus.mem_valid !== 1'b0) begin
            errors++;
            $display("FAIL redirect_no_req got mem_valid %b expected 0", bus.mem_valid);
          end
          exp_q.delete();
          exp_pc = bus.redirect_pc & ~32'h3;
        end
        if (pend_due.size() != 0 && pend_due[0] <= cyc) begin
          bus.mem_rvalid = 1'b1;
          bus.mem_rdata  = pend_addr.pop_front() ^ K;
          void'(pend_due.pop_front());
        end else begin
          bus.mem_rvalid = 1'b0;
          bus.mem_rdata  = 32'h0;
        end
        if (bus.mem_valid && bus.mem_ready) begin
          checks++;
          if (bus.mem_addr !== exp_pc) begin
            errors++;
            $display("FAIL req_addr got %h expected %h", bus.mem_addr, exp_pc);
          end
          pend_addr.push_back(bus.mem_addr);
          pend_due.push_back(cyc + lat);
          exp_q.push_back(exp_pc);
          exp_pc = exp_pc + 32'd4;
          n_acc++;
        end
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset(input int l, input logic ir);
    rst = 1'b1;
    bus.redirect = 1'b0;
    bus.mem_ready = 1'b1;
    bus.inst_ready = ir;
    lat = l;
    tick();
    tick();
    rst = 1'b0;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    bus.redirect = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.mem_ready = 1'b1;
    bus.inst_ready = 1'b1;
    lat = 1;
    tick();
    tick();
    @(negedge clk);
    checks++;
    if ({bus.mem_valid, bus.inst_valid} !== 2'b00) begin
      errors++;
      $display("FAIL reset_valids got %b expected 00", {bus.mem_valid, bus.inst_valid});
    end
    checks++;
    if (bus.mem_addr !== 32'h0) begin
      errors++;
      $display("FAIL reset_mem_addr got %h expected 0", bus.mem_addr);
    end
    checks++;
    if ({bus.inst_data, bus.inst_addr} !== 64'h0) begin
      errors++;
      $display("FAIL reset_inst got data %h addr %h expected 0", bus.inst_data, bus.inst_addr);
    end
    tick();
    rst = 1'b0;
  endtask
  task automatic test_stream();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if (bus.mem_valid !== 1'b1 || bus.mem_addr !== 32'(4 * c)) begin
        errors++;
        $display("FAIL stream_req c%0d got %b/%h expected 1/%h", c, bus.mem_valid, bus.mem_addr, 32'(4 * c));
      end
      if (c >= 2) begin
        checks++;
        if (bus.inst_valid !== 1'b1 || bus.inst_addr !== 32'(4 * (c - 2))) begin
          errors++;
          $display("FAIL stream_inst c%0d got %b/%h expected 1/%h", c, bus.inst_valid, bus.inst_addr, 32'(4 * (c - 2)));
        end
      end
    end
  endtask
  task automatic test_backpressure();
    bit found = 0;
    do_reset(1, 1'b0);
    repeat (8) @(negedge clk);
    checks++;
    if (bus.mem_valid !== 1'b0 || n_acc != 4) begin
      errors++;
      $display("FAIL bp_stall got mem_valid %b accepted %0d expected 0/4", bus.mem_valid, n_acc);
    end
    checks++;
    if (dut.count !== 3'd4 || bus.inst_addr !== 32'h0) begin
      errors++;
      $display("FAIL bp_full got count %0d head %h expected 4/0", dut.count, bus.inst_addr);
    end
    tick();
    bus.inst_ready = 1'b1;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (bus.mem_valid && bus.mem_ready) found = 1;
    end
    checks++;
    if (!found || bus.mem_addr !== 32'h10) begin
      errors++;
      $display("FAIL bp_resume got found %0d addr %h expected 1/00000010", found, bus.mem_addr);
    end
  endtask
  task automatic test_redirect_inflight();
    bit found = 0;
    do_reset(3, 1'b1);
    repeat (3) tick();
    checks++;
    if (dut.outstanding !== 3'd3) begin
      errors++;
      $display("FAIL rd_outstanding got %0d expected 3", dut.outstanding);
    end
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h0000_0103;
    tick();
    bus.redirect = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.mem_valid !== 1'b1 || bus.mem_addr !== 32'h100) begin
      errors++;
      $display("FAIL rd_req got %b/%h expected 1/00000100", bus.mem_valid, bus.mem_addr);
    end
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (bus.inst_valid) found = 1;
    end
    checks++;
    if (!found || bus.inst_addr !== 32'h100) begin
      errors++;
      $display("FAIL rd_first got found %0d addr %h expected 1/00000100", found, bus.inst_addr);
    end
  endtask
  task automatic test_redirect_pop();
    do_reset(1, 1'b1);
    repeat (5) tick();
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h0000_0200;
    @(negedge clk);
    checks++;
    if ({bus.inst_valid, bus.inst_ready, bus.mem_rvalid} !== 3'b111) begin
      errors++;
      $display("FAIL rp_coincide got %b expected 111", {bus.inst_valid, bus.inst_ready, bus.mem_rvalid});
    end
    tick();
    bus.redirect = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.inst_valid !== 1'b0 || bus.mem_valid !== 1'b1 || bus.mem_addr !== 32'h200) begin
      errors++;
      $display("FAIL rp_flush got %b/%b/%h expected 0/1/00000200", bus.inst_valid, bus.mem_valid, bus.mem_addr);
    end
    @(negedge clk);
    checks++;
    if (bus.inst_valid !== 1'b0) begin
      errors++;
      $display("FAIL rp_empty got inst_valid %b expected 0", bus.inst_valid);
    end
    @(negedge clk);
    checks++;
    if (bus.inst_valid !== 1'b1 || bus.inst_addr !== 32'h200) begin
      errors++;
      $display("FAIL rp_first got %b/%h expected 1/00000200", bus.inst_valid, bus.inst_addr);
    end
  endtask
  task automatic test_wrap();
    wrap_exp = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
    tick();
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'hFFFF_FFF8;
    tick();
    bus.redirect = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (bus.inst_valid !== 1'b1 || bus.inst_addr !== wrap_exp[i]) begin
        errors++;
        $display("FAIL wrap_%0d got %b/%h expected 1/%h", i, bus.inst_valid, bus.inst_addr, wrap_exp[i]);
      end
    end
  endtask
  task automatic test_reset_mid();
    bit found = 0;
    tick();
    bus.inst_ready = 1'b0;
    repeat (8) @(negedge clk);
    checks++;
    if (dut.count !== 3'd4) begin
      errors++;
      $display("FAIL rm_full got count %0d expected 4", dut.count);
    end
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({bus.mem_valid, bus.inst_valid} !== 2'b00 || bus.mem_addr !== 32'h0 || {bus.inst_data, bus.inst_addr} !== 64'h0) begin
      errors++;
      $display("FAIL rm_outputs got %b/%b/%h/%h/%h expected all 0", bus.mem_valid, bus.inst_valid, bus.mem_addr, bus.inst_data, bus.inst_addr);
    end
    checks++;
    if (dut.outstanding !== 3'd0 || dut.drop_cnt !== 3'd0) begin
      errors++;
      $display("FAIL rm_counters got %0d/%0d expected 0/0", dut.outstanding, dut.drop_cnt);
    end
    tick();
    rst = 1'b0;
    bus.inst_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.mem_valid !== 1'b1 || bus.mem_addr !== 32'h0) begin
      errors++;
      $display("FAIL rm_restart got %b/%h expected 1/00000000", bus.mem_valid, bus.mem_addr);
    end
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (bus.inst_valid) found = 1;
    end
    checks++;
    if (!found || bus.inst_addr !== 32'h0) begin
      errors++;
      $display("FAIL rm_first got found %0d addr %h expected 1/00000000", found, bus.inst_addr);
    end
  endtask
  initial begin
    bus.mem_ready = 1'b1;
    bus.inst_ready = 1'b1;
    bus.redirect = 1'b0;
    bus.redirect_pc = 32'h0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_inflight();
    test_redirect_pop();
    test_wrap();
    test_reset_mid();
    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "timeout");
  end
endmodule
